// File: rtl/add_subt_pkg.sv
// add_subt_pkg: op encodings and segment-width helper shared by the adder pipe
package add_subt_pkg;
   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_RSUB = 2'b10;
   localparam logic [1:0] OP_ABS  = 2'b11;
   function automatic int seg_w(input int swr, input int segs);
      return swr / segs;
   endfunction
endpackage

// File: rtl/add_subt_pipe_if.sv
// add_subt_pipe_if: operand/result handshake bundle of the adder pipe
interface add_subt_pipe_if #(parameter int SWR = 26);
   logic           in_valid_i;
   logic           in_ready_o;
   logic           FSM_Select_i;
   logic [1:0]     Op0_i;
   logic [1:0]     Op1_i;
   logic [SWR-1:0] Oper0_A_i;
   logic [SWR-1:0] Oper1_A_i;
   logic [SWR-1:0] Oper0_B_i;
   logic [SWR-1:0] Oper1_B_i;
   logic           out_valid_o;
   logic           out_ready_i;
   logic [SWR-1:0] Data_Result_o;
   logic [SWR-1:0] P_o;
   logic           C_o;
   logic           Neg_o;
   logic           Zero_o;
   modport master (
      output in_valid_i, FSM_Select_i, Op0_i, Op1_i, Oper0_A_i, Oper1_A_i, Oper0_B_i, Oper1_B_i, out_ready_i,
      input  in_ready_o, out_valid_o, Data_Result_o, P_o, C_o, Neg_o, Zero_o
   );
   modport slave (
      input  in_valid_i, FSM_Select_i, Op0_i, Op1_i, Oper0_A_i, Oper1_A_i, Oper0_B_i, Oper1_B_i, out_ready_i,
      output in_ready_o, out_valid_o, Data_Result_o, P_o, C_o, Neg_o, Zero_o
   );
endinterface

// File: rtl/add_subt_pipe_add_seg.sv
// add_seg: one W-bit slice of the split carry chain, with its propagate bits
module add_seg #(parameter int W = 13) (
   input  logic [W-1:0] X,
   input  logic [W-1:0] Y,
   input  logic         cin,
   output logic [W-1:0] S,
   output logic [W-1:0] P,
   output logic         cout
);
   assign P = X ^ Y;
   assign {cout, S} = {1'b0, X} + {1'b0, Y} + {{W{1'b0}}, cin};
endmodule

// File: rtl/add_subt_pipe.sv
// add_subt_pipe: pipelined significand ADD/SUB/RSUB/ABS with a segmented carry chain
module add_subt_pipe
   import add_subt_pkg::*;
#(
   parameter int SWR  = 26,
   parameter int SEGS = 2
) (
   input logic            clk,
   input logic            rst,
   add_subt_pipe_if.slave bus
);
   localparam int SEG_W = seg_w(SWR, SEGS);
   if (SWR % SEGS != 0) begin : g_bad_segs
      $error("add_subt_pipe: SWR must be a multiple of SEGS");
   end
   // a_q[k] holds sum bits below segment k and X bits from segment k up;
   // b_q[k] likewise holds propagate bits below segment k and Y bits above.
   logic                      adv;
   logic [1:0]                op_in;
   logic [SWR-1:0]            a_in, b_in, x_in, y_in;
   logic [SEGS:0][SWR-1:0]    a_q, b_q;
   logic [SEGS-1:0][SWR-1:0]  a_d, b_d;
   logic [SEGS:0][1:0]        op_q;
   logic [SEGS:0]             c_q, v_q;
   logic [SEGS-1:0]           c_d;
   logic                      abs_neg;
   logic [SWR-1:0]            res;
   assign adv = !bus.out_valid_o || bus.out_ready_i;
   assign bus.in_ready_o = adv;
   // pick the operand channel and map the op onto adder inputs X and Y
   always_comb begin
      op_in = bus.FSM_Select_i ? bus.Op1_i : bus.Op0_i;
      a_in  = bus.FSM_Select_i ? bus.Oper1_A_i : bus.Oper0_A_i;
      b_in  = bus.FSM_Select_i ? bus.Oper1_B_i : bus.Oper0_B_i;
      x_in  = (op_in == OP_RSUB) ? b_in : a_in;
      y_in  = (op_in == OP_ADD) ? b_in : (op_in == OP_RSUB) ? ~a_in : ~b_in;
   end
   for (genvar k = 0; k < SEGS; k++) begin : g_seg
      localparam logic [SWR-1:0] M = SWR'({SEG_W{1'b1}}) << (k * SEG_W);
      logic [SEG_W-1:0] s, p;
      add_seg #(.W(SEG_W)) u_seg (
         .X    (a_q[k][k*SEG_W +: SEG_W]),
         .Y    (b_q[k][k*SEG_W +: SEG_W]),
         .cin  (c_q[k]),
         .S    (s),
         .P    (p),
         .cout (c_d[k])
      );
      assign a_d[k] = (a_q[k] & ~M) | (SWR'(s) << (k * SEG_W));
      assign b_d[k] = (b_q[k] & ~M) | (SWR'(p) << (k * SEG_W));
   end
   // a negative ABS result is the two's complement of the raw sum
   always_comb begin
      abs_neg = (op_q[SEGS] == OP_ABS) && !c_q[SEGS];
      res     = abs_neg ? ~a_q[SEGS] + SWR'(1) : a_q[SEGS];
   end
   // the whole pipe shifts together on adv; reset flushes it and clears outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q               <= '0;
         a_q               <= '0;
         b_q               <= '0;
         c_q               <= '0;
         op_q              <= '0;
         bus.out_valid_o   <= 1'b0;
         bus.Data_Result_o <= '0;
         bus.P_o           <= '0;
         bus.C_o           <= 1'b0;
         bus.Neg_o         <= 1'b0;
         bus.Zero_o        <= 1'b0;
      end else if (adv) begin
         v_q               <= {v_q[SEGS-1:0], bus.in_valid_i};
         a_q               <= {a_d, x_in};
         b_q               <= {b_d, y_in};
         c_q               <= {c_d, op_in != OP_ADD};
         op_q              <= {op_q[SEGS-1:0], op_in};
         bus.out_valid_o   <= v_q[SEGS];
         bus.Data_Result_o <= res;
         bus.P_o           <= b_q[SEGS];
         bus.C_o           <= c_q[SEGS];
         bus.Neg_o         <= abs_neg;
         bus.Zero_o        <= res == '0;
      end
   end
endmodule

// File: doc/add_subt_pipe.md
# add_subt_pipe

Parametrised, pipelined significand adder/subtractor and successor to the single-register add/subtract unit in the FPU datapath. It sits between the alignment shifter and the LZA/normaliser. It selects one of two operand channels, then runs ADD, SUB, reverse-SUB or absolute-difference over a carry chain split into SEGS registered segments. A valid/ready handshake with full backpressure gives one result per cycle.

## Interface
- SWR, 26, significand word width in bits
- SEGS, 2, number of carry-chain segments; SWR % SEGS must be 0 (elaboration error otherwise); SEG_W = SWR/SEGS

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid_i  in  1  input operands valid
- in_ready_o  out  1  block accepts input this cycle
- FSM_Select_i  in  1  channel select: 0 → Oper0_*/Op0_i, 1 → Oper1_*/Op1_i
- Op0_i, Op1_i  in  2 each  operation per channel: 00 ADD A+B, 01 SUB A−B, 10 RSUB B−A, 11 ABS |A−B|
- Oper0_A_i, Oper1_A_i  in  SWR each  operand A per channel
- Oper0_B_i, Oper1_B_i  in  SWR each  operand B per channel
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts result
- Data_Result_o  out  SWR  result
- P_o  out  SWR  propagate vector (X ^ Y after operand inversion), for LZA
- C_o  out  1  carry out of MSB
- Neg_o  out  1  ABS only: 1 when A < B
- Zero_o  out  1  Data_Result_o == 0

## Operation
- Accept occurs when in_valid_i && in_ready_o. Channel select, op, A and B are captured at accept only.
- Operand mapping:
  - ADD: X=A, Y=B, cin=0.
  - SUB and ABS: X=A, Y=~B, cin=1.
  - RSUB: X=B, Y=~A, cin=1.
- Arithmetic is unsigned modulo 2^SWR. For SUB, C_o=1 means no borrow (A ≥ B).
- Stage k (0..SEGS−1) adds segment k (bits k·SEG_W+SEG_W−1 : k·SEG_W) with the carry registered by stage k−1; stage 0 uses cin.
  - Upper unsummed segments are delayed alongside the computation.
  - Lower sum segments, op and per-segment propagate bits are delayed alongside as well.
- Final stage (SEGS) registers the outputs.
  - If op=ABS and carry=0: Data_Result_o = (~S)+1 (full-width, combinational within this stage), Neg_o=1.
  - Otherwise Data_Result_o = S, Neg_o=0.
  - C_o is the raw carry before ABS correction.
  - Zero_o is computed on the final corrected result.
- ABS with A=B gives result 0, Neg_o=0, C_o=1.
- Every stage has a valid bit. Bubbles propagate; registers hold when stalled.
- Global advance: adv = !out_valid_o || out_ready_i. in_ready_o = adv. All stage registers, including valid bits, load only when adv=1.
- When in_valid_i=0 at adv, a bubble (valid=0) enters stage 0.
- Reset: all valid bits 0 and all output registers 0. This means out_valid_o=0, Data_Result_o=0, P_o=0, C_o=0, Neg_o=0, Zero_o=0, and in_ready_o=1.
- Reset mid-operation discards all in-flight operations. Reset dominates any simultaneous accept.

## Timing
- Latency: SEGS+1 cycles from the accept edge to out_valid_o high, with no stall. For SEGS=2, a result accepted at edge n is visible after edge n+3.
- Throughput: 1 operation per cycle while out_ready_i=1.
- out_valid_o=1 with out_ready_i=0 freezes the whole pipe. Outputs hold stable and in_ready_o=0 in the same cycle (combinational from out_ready_i).
- Simultaneous result consume and new accept in one cycle is legal. The pipe shifts by one.
- Results are delivered in order. There is no loss and no duplication.
- Critical path per stage: one SEG_W-bit carry chain. The final stage is the SWR-bit increment for ABS.

## Structure
- Shared package add_subt_pkg holds:
  - localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_RSUB=2'b10, OP_ABS=2'b11.
  - A SEG_W helper function.
- One sub-module, add_seg: SEG_W-bit combinational adder with ports X, Y, cin → S, cout, P. Instantiate it SEGS times in a generate loop.
- The pipeline registers and the handshake live in add_subt_pipe.

## Test plan
- ADD, SWR=26, SEGS=2, A=26'h3FFFFFF, B=26'h0000001 → after 3 cycles: Data_Result_o=0, C_o=1, Zero_o=1, Neg_o=0.
- SUB A=5, B=7 → 26'h3FFFFFE, C_o=0. Same operands with ABS → 2, Neg_o=1, C_o=0. RSUB A=5, B=7 → 2, C_o=1.
- Segment-boundary carry: ADD A=26'h0001FFF (SEG_W=13), B=1 → 26'h0002000, P_o=26'h0001FFE. Also run with FSM_Select_i=1 on the Oper1_* inputs and get identical results.
- Streaming: 8 back-to-back random ops, out_ready_i held low for 4 cycles mid-stream.
  - in_ready_o=0 throughout the stall and outputs stable.
  - All 8 results match the reference model, in order.
- rst asserted for 1 cycle with 3 ops in flight → next cycle out_valid_o=0, all outputs 0, in_ready_o=1. No stale result appears afterward.
- ABS A=B=26'h1234567 → 0, Zero_o=1, Neg_o=0, C_o=1.
